// File: rtl/param_sync_fifo.sv
// Single-clock parameterised FIFO with registered fill level, sticky error flags,
// and either registered-output (FWFT=0) or first-word-fall-through (FWFT=1) reads.
module param_sync_fifo #(
  parameter int DATA_WIDTH         = 4,
  parameter int ADDRESS_WIDTH      = 5,
  parameter int ALMOST_FULL_LEVEL  = (2 ** ADDRESS_WIDTH) - 4,
  parameter int ALMOST_EMPTY_LEVEL = 4,
  parameter bit FWFT               = 1'b0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    write_data,
  input  logic                     write_increment,
  input  logic                     read_increment,
  input  logic                     clear_errors,
  output logic [DATA_WIDTH-1:0]    read_data,
  output logic                     read_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [ADDRESS_WIDTH:0]   fill_level,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int                     DEPTH     = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH:0] DEPTH_LVL = (ADDRESS_WIDTH + 1)'(DEPTH);
  localparam logic [ADDRESS_WIDTH:0] AF_LVL    = (ADDRESS_WIDTH + 1)'(ALMOST_FULL_LEVEL);
  localparam logic [ADDRESS_WIDTH:0] AE_LVL    = (ADDRESS_WIDTH + 1)'(ALMOST_EMPTY_LEVEL);

  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] wr_ptr;
  logic [ADDRESS_WIDTH-1:0] rd_ptr;
  logic                     write_accept;
  logic                     read_accept;

  // All flags decode straight from the fill_level register so none of them lag it.
  assign empty        = (fill_level == '0);
  assign full         = (fill_level == DEPTH_LVL);
  assign almost_full  = (fill_level >= AF_LVL);
  assign almost_empty = (fill_level <= AE_LVL);

  assign write_accept = write_increment && !full;
  assign read_accept  = read_increment && !empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (write_accept) wr_ptr <= wr_ptr + 1'b1;
      if (read_accept)  rd_ptr <= rd_ptr + 1'b1;
      if (write_accept && !read_accept)      fill_level <= fill_level + 1'b1;
      else if (read_accept && !write_accept) fill_level <= fill_level - 1'b1;
    end
  end

  // Storage carries no reset; gating on reset keeps a write from landing during reset.
  always_ff @(posedge clock) begin
    if (write_accept && !reset) mem[wr_ptr] <= write_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_increment && full) overflow <= 1'b1;
      else if (clear_errors)       overflow <= 1'b0;
      if (read_increment && empty) underflow <= 1'b1;
      else if (clear_errors)       underflow <= 1'b0;
    end
  end

  if (FWFT == 1'b0) begin : g_std
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;

    always_ff @(posedge clock) begin
      if (reset) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= read_accept;
        if (read_accept) data_q <= mem[rd_ptr];
      end
    end

    assign read_data  = data_q;
    assign read_valid = valid_q;
  end else begin : g_fwft
    // Head is shown only while an entry exists, so stale storage never leaks out.
    assign read_valid = !empty;
    assign read_data  = empty ? '0 : mem[rd_ptr];
  end

endmodule
